// File: rtl/count_sched.sv
// count_sched: round-robin arbiter granting a shared down-counter to one of NREQ requesters.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   req  - level request per requester
//   len  - packed count per requester, field i = len[i*WIDTH +: WIDTH]
//   gnt  - one-cycle one-hot grant pulse to the winner
//   done - one-cycle one-hot completion pulse to the owner
//   busy - high while the counter is owned
//   cnt  - current value of the shared down-counter
module count_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      cnt
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic [IW-1:0]     owner_q, owner_d, ptr_q, ptr_d, win;
    logic              found;
    // ptr_q is the first requester examined; it moves past each winner
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                win   = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        done_d  = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d      = RUN;
                cnt_d        = len[int'(win)*WIDTH +: WIDTH];
                gnt_d[win]   = 1'b1;
                owner_d      = win;
                ptr_d        = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            state_d         = IDLE;
            done_d[owner_q] = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end
    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q == RUN);
    assign cnt  = cnt_q;
endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched: directed scoreboard bench for count_sched (WIDTH=16, NREQ=2).
module tb_count_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] len0 = '0, len1 = '0;
    logic [31:0] len;
    logic [1:0]  gnt, done;
    logic        busy;
    logic [15:0] cnt;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    typedef struct {
        int         c;
        logic [1:0] g;
        logic [1:0] d;
    } ev_t;
    ev_t exp_q[$];
    assign len = {len1, len0};
    count_sched #(.WIDTH(16), .NREQ(2)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len),
        .gnt(gnt), .done(done), .busy(busy), .cnt(cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask
    task automatic push_ev(input int c, input logic [1:0] g, input logic [1:0] d);
        ev_t e;
        e.c = c;
        e.g = g;
        e.d = d;
        exp_q.push_back(e);
    endtask
    // every gnt/done pulse must match the oldest expected event, cycle included
    always @(negedge clk) begin
        if (gnt != 2'b00 || done != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 64'({cyc, gnt, done}), 64'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event", 64'({cyc, gnt, done}), 64'({e.c, e.g, e.d}));
            end
        end
    end
    initial begin
        int e0;
        int g;
        bit ok;
        logic [15:0] prev;
        tick();
        tick();
        check("reset_state", 64'({cnt, gnt, done, busy}), 64'd0);
        // basic count of 3 on requester 0
        len0 = 16'd3;
        req  = 2'b01;
        rst  = 1'b0;
        e0   = cyc;
        push_ev(e0 + 1, 2'b01, 2'b00);
        push_ev(e0 + 5, 2'b00, 2'b01);
        tick();
        req = 2'b00;
        check("basic_cnt3", 64'({busy, cnt}), 64'({1'b1, 16'd3}));
        tick();
        check("basic_cnt2", 64'({busy, cnt}), 64'({1'b1, 16'd2}));
        tick();
        check("basic_cnt1", 64'({busy, cnt}), 64'({1'b1, 16'd1}));
        tick();
        check("basic_cnt0", 64'({busy, cnt}), 64'({1'b1, 16'd0}));
        tick();
        check("basic_idle", 64'({busy, cnt}), 64'({1'b0, 16'd0}));
        tick();
        // alternating grants with both requesting from reset
        rst = 1'b1;
        tick();
        tick();
        len0 = 16'd2;
        len1 = 16'd5;
        req  = 2'b11;
        rst  = 1'b0;
        e0   = cyc;
        g    = e0 + 1;
        for (int i = 0; i < 4; i++) begin
            push_ev(g, (i % 2) ? 2'b10 : 2'b01, 2'b00);
            push_ev(g + ((i % 2) ? 5 : 2) + 1, 2'b00, (i % 2) ? 2'b10 : 2'b01);
            g = g + ((i % 2) ? 5 : 2) + 2;
        end
        wait_until(g - 7);
        req = 2'b00;
        wait_until(g + 1);
        check("rr_busy_end", 64'(busy), 64'd0);
        // zero length: one RUN cycle
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        len0 = 16'd0;
        req  = 2'b01;
        e0   = cyc;
        push_ev(e0 + 1, 2'b01, 2'b00);
        push_ev(e0 + 2, 2'b00, 2'b01);
        tick();
        req = 2'b00;
        check("zero_run", 64'({busy, cnt}), 64'({1'b1, 16'd0}));
        tick();
        check("zero_done", 64'({busy, cnt}), 64'({1'b0, 16'd0}));
        tick();
        // full-range count on requester 1
        len1 = 16'hFFFF;
        req  = 2'b10;
        e0   = cyc;
        push_ev(e0 + 1, 2'b10, 2'b00);
        push_ev(e0 + 65537, 2'b00, 2'b10);
        tick();
        req = 2'b00;
        check("max_load", 64'({busy, cnt}), 64'({1'b1, 16'hFFFF}));
        ok   = 1'b1;
        prev = cnt;
        for (int i = 0; i < 65535; i++) begin
            tick();
            if (busy !== 1'b1 || cnt !== prev - 16'd1) ok = 1'b0;
            prev = cnt;
        end
        check("max_monotonic_busy", 64'(ok), 64'd1);
        check("max_last", 64'({busy, cnt}), 64'({1'b1, 16'd0}));
        tick();
        check("max_done_idle", 64'({busy, cnt}), 64'({1'b0, 16'd0}));
        tick();
        // reset mid-RUN aborts without done and restores requester 0 priority
        len0 = 16'd10;
        req  = 2'b01;
        e0   = cyc;
        push_ev(e0 + 1, 2'b01, 2'b00);
        tick();
        req = 2'b00;
        wait_until(e0 + 4);
        check("abort_cnt7", 64'({busy, cnt}), 64'({1'b1, 16'd7}));
        rst  = 1'b1;
        req  = 2'b11;
        len0 = 16'd1;
        len1 = 16'd1;
        tick();
        check("abort_reset", 64'({busy, cnt}), 64'd0);
        tick();
        check("abort_hold", 64'({busy, cnt}), 64'd0);
        rst = 1'b0;
        push_ev(e0 + 7, 2'b01, 2'b00);
        push_ev(e0 + 9, 2'b00, 2'b01);
        push_ev(e0 + 10, 2'b10, 2'b00);
        push_ev(e0 + 12, 2'b00, 2'b10);
        wait_until(e0 + 10);
        req = 2'b00;
        wait_until(e0 + 13);
        // owner drops req and len changes mid-RUN
        len0 = 16'd4;
        req  = 2'b01;
        e0   = cyc;
        push_ev(e0 + 1, 2'b01, 2'b00);
        push_ev(e0 + 6, 2'b00, 2'b01);
        tick();
        req  = 2'b00;
        len0 = 16'd9;
        tick();
        check("ignore_cnt3", 64'({busy, cnt}), 64'({1'b1, 16'd3}));
        wait_until(e0 + 8);
        check("ignore_idle", 64'({busy, cnt}), 64'd0);
        check("events_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter WIDTH, default 16, width of each count field and of the shared down-counter.
REQ-002 Parameter NREQ, default 2, number of requesters sharing the counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  NREQ  level request per requester; bit i = requester i.
REQ-006 len  input  NREQ*WIDTH  packed count per requester; field i = len[i*WIDTH +: WIDTH].
REQ-007 gnt  output  NREQ  one-hot, one-cycle grant pulse to the winning requester.
REQ-008 done  output  NREQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-009 busy  output  1  high while the counter is owned (state RUN).
REQ-010 cnt  output  WIDTH  current value of the shared down-counter.

Function
REQ-011 The FSM SHALL have two states, IDLE and RUN, with all outputs registered.
REQ-012 In IDLE with req == 0, the state SHALL stay IDLE, cnt SHALL hold, and gnt/done SHALL be 0.
REQ-013 In IDLE with req != 0 at edge T, arbitration SHALL pick winner w round-robin.
REQ-014 At edge T+1 the block SHALL assert gnt[w], load cnt = len field w sampled at T, record owner = w, and enter RUN.
REQ-015 Round-robin order: search starts at (last winner + 1) mod NREQ; after reset, search starts at requester 0.
REQ-016 In RUN with cnt != 0, cnt SHALL decrement by 1 per cycle, with no wrap and no underflow.
REQ-017 In RUN with cnt == 0, the next edge SHALL pulse done[owner] for one cycle, enter IDLE, and hold cnt at 0.
REQ-018 Latency: len = L granted at T+1 SHALL produce done at T+L+2; busy SHALL be high from T+1 through T+L+1 inclusive.
REQ-019 len = 0 SHALL produce gnt at T+1 and done at T+2 (one RUN cycle).
REQ-020 len = all-ones (0xFFFF for WIDTH=16) SHALL count fully with no overflow; done SHALL arrive at T+65537.
REQ-021 When done asserts (the IDLE cycle), a pending req SHALL be arbitrated in that same cycle, with gnt on the following edge; the minimum gap between done and the next gnt is one cycle.
REQ-022 req and len changes during RUN SHALL be ignored; deasserting the owner's req SHALL NOT abort the count.
REQ-023 gnt and done SHALL never be high in the same cycle, and at most one bit of each SHALL be set.
REQ-024 A requester SHALL be considered served once granted; if it is still requesting at the next IDLE, it is arbitrated again under the round-robin rule.

Reset
REQ-025 Reset values: state IDLE, cnt 0, gnt 0, done 0, busy 0, owner 0, round-robin pointer so that requester 0 has priority.
REQ-026 rst asserted in any state, including mid-RUN, SHALL take effect at the next edge and override all other inputs; no done pulse SHALL be emitted for the aborted count.
REQ-027 While rst is high, req SHALL be ignored.

Verification
REQ-028 Reset release, req=2'b01, len0=3 -> gnt=01 at T+1; cnt 3,2,1,0; done=01 at T+5; busy high for 4 cycles.
REQ-029 req=2'b11 held, len0=2, len1=5, both held from reset -> grants alternate 0,1,0,1; each done matches its owner; one idle cycle between done and the next gnt.
REQ-030 len0=0 -> gnt at T+1, done at T+2, cnt stays 0.
REQ-031 len1=16'hFFFF -> done at T+65537; cnt never wraps; busy is continuous.
REQ-032 rst pulsed while cnt=7 in RUN -> next cycle cnt=0, busy=0, no done; next req=2'b11 grants requester 0 first.
REQ-033 Owner drops req and len changes to 9 mid-RUN -> count continues from the original len and done still pulses to the owner.
